// File: rtl/mul_sched.sv
// mul_sched: round-robin scheduler sharing one WIDTH-bit multiplier among NREQ requesters,
// through an operand stage and a multiply/result stage with tagged, backpressured results.
`ifndef WIDTH
`define WIDTH 8
`endif
module mul_sched #(
    parameter int WIDTH = `WIDTH,
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ),
    parameter int CNTW  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NREQ-1:0]       req_valid_i,
    output logic [NREQ-1:0]       req_ready_o,
    input  logic [NREQ*WIDTH-1:0] req_in0_i,
    input  logic [NREQ*WIDTH-1:0] req_in1_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [IDW-1:0]        resp_id_o,
    output logic [WIDTH-1:0]      resp_out_o,
    output logic                  busy_o,
    output logic [CNTW-1:0]       op_count_o
);
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d, winner, idx;
    logic             found, accept, adv1, adv2, retire;
    logic             s1_valid_q, s1_valid_d, resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0] s1_in0_q, s1_in0_d, s1_in1_q, s1_in1_d, resp_out_q, resp_out_d, prod;
    logic [IDW-1:0]   s1_id_q, s1_id_d, resp_id_q, resp_id_d;
    logic [CNTW-1:0]  op_count_q, op_count_d;

    assign adv2   = !resp_valid_q || resp_ready_i;
    assign adv1   = !s1_valid_q || adv2;
    assign retire = resp_valid_q && resp_ready_i;
    assign accept = found && adv1;
    assign prod   = s1_in0_q * s1_in1_q;

    // Rotating priority: the scan starts just after the last accepted requester.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDW'((int'(rr_ptr_q) + k) % NREQ);
            if (!found && req_valid_i[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        rr_ptr_d     = accept ? winner : rr_ptr_q;
        s1_valid_d   = adv1 ? accept : s1_valid_q;
        s1_in0_d     = accept ? req_in0_i[int'(winner)*WIDTH +: WIDTH] : s1_in0_q;
        s1_in1_d     = accept ? req_in1_i[int'(winner)*WIDTH +: WIDTH] : s1_in1_q;
        s1_id_d      = accept ? winner : s1_id_q;
        resp_valid_d = adv2 ? s1_valid_q : resp_valid_q;
        resp_out_d   = (adv2 && s1_valid_q) ? prod : resp_out_q;
        resp_id_d    = (adv2 && s1_valid_q) ? s1_id_q : resp_id_q;
        op_count_d   = op_count_q + CNTW'(retire);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q     <= IDW'(NREQ - 1);
            s1_valid_q   <= 1'b0;
            s1_in0_q     <= '0;
            s1_in1_q     <= '0;
            s1_id_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_out_q   <= '0;
            resp_id_q    <= '0;
            op_count_q   <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            s1_valid_q   <= s1_valid_d;
            s1_in0_q     <= s1_in0_d;
            s1_in1_q     <= s1_in1_d;
            s1_id_q      <= s1_id_d;
            resp_valid_q <= resp_valid_d;
            resp_out_q   <= resp_out_d;
            resp_id_q    <= resp_id_d;
            op_count_q   <= op_count_d;
        end
    end

    assign req_ready_o  = accept ? (NREQ'(1) << winner) : '0;
    assign resp_valid_o = resp_valid_q;
    assign resp_id_o    = resp_id_q;
    assign resp_out_o   = resp_out_q;
    assign busy_o       = s1_valid_q || resp_valid_q;
    assign op_count_o   = op_count_q;
endmodule

// File: tb/tb_mul_sched.sv
// tb_mul_sched: directed stimulus with a queue-based reference model checked every cycle,
// plus literal expectations for each scenario.
module tb_mul_sched;
    logic        clk = 1'b0, rst = 1'b1;
    logic [3:0]  req_valid = '0, req_ready;
    logic [31:0] in0 = '0, in1 = '0;
    logic        resp_valid, resp_ready = 1'b1, busy;
    logic [1:0]  resp_id;
    logic [7:0]  resp_out;
    logic [31:0] op_count;
    int          n_chk = 0, n_fail = 0;

    mul_sched #(.WIDTH(8), .NREQ(4), .CNTW(32)) dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_in0_i(in0), .req_in1_i(in1), .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_id_o(resp_id), .resp_out_o(resp_out), .busy_o(busy), .op_count_o(op_count)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Requester-side queues of pending operands.
    logic [7:0] qa [4][32];
    logic [7:0] qb [4][32];
    int         hd [4] = '{0, 0, 0, 0};
    int         tl [4] = '{0, 0, 0, 0};
    logic [3:0] fire = '0;

    task automatic push(int i, int a, int b);
        qa[i][tl[i]] = 8'(a);
        qb[i][tl[i]] = 8'(b);
        tl[i]++;
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (fire[i]) hd[i]++;
            req_valid[i] = hd[i] < tl[i];
            in0[i*8 +: 8] = (hd[i] < tl[i]) ? qa[i][hd[i]] : 8'h00;
            in1[i*8 +: 8] = (hd[i] < tl[i]) ? qb[i][hd[i]] : 8'h00;
        end
    end

    // Reference model: at most two ops in flight, in order; an op reaches the output one edge after acceptance.
    typedef struct { int id; logic [7:0] p; int acc; } ent_t;
    ent_t        mq[$];
    int          glog[$];
    int          mptr = 3, edge_n = 0, m_win;
    logic [31:0] mcnt = '0, m_a, m_b;
    logic [3:0]  m_rdy;
    logic        m_rv;

    always @(negedge clk) begin
        if (rst) begin
            mq.delete();
            mptr = 3;
            mcnt = '0;
            fire = '0;
        end
        m_win = -1;
        for (int k = 1; k <= 4; k++)
            if (m_win < 0 && req_valid[(mptr + k) % 4]) m_win = (mptr + k) % 4;
        m_rdy = (m_win >= 0 && (mq.size() < 2 || resp_ready)) ? 4'(1 << m_win) : 4'b0;
        m_rv = mq.size() > 0 && (edge_n - mq[0].acc) >= 1;
        chk("req_ready", req_ready, m_rdy);
        chk("resp_valid", resp_valid, m_rv);
        chk("busy", busy, mq.size() > 0);
        chk("op_count", op_count, mcnt);
        if (m_rv) begin
            chk("resp_id", resp_id, mq[0].id);
            chk("resp_out", resp_out, mq[0].p);
        end
        if (!rst) begin
            if (m_rv && resp_ready) begin
                void'(mq.pop_front());
                mcnt++;
            end
            edge_n++;
            fire = m_rdy & req_valid;
            if (fire != 0) begin
                m_a = (in0 >> (8 * m_win)) & 32'hFF;
                m_b = (in1 >> (8 * m_win)) & 32'hFF;
                mq.push_back('{m_win, 8'((m_a * m_b) % 256), edge_n});
                mptr = m_win;
                glog.push_back(m_win);
            end
        end
    end

    task automatic wait_resp(int id, int val, string nm);
        bit got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (resp_valid && resp_ready) got = 1;
        end
        chk({nm, " seen"}, got, 1);
        if (got) begin
            chk({nm, " id"}, resp_id, id);
            chk({nm, " out"}, resp_out, val);
        end
    endtask

    task automatic drain(string nm);
        bit idle = 0;
        for (int i = 0; i < 80 && !idle; i++) begin
            @(posedge clk);
            #3;
            idle = mq.size() == 0 && req_valid == 0 && !busy;
        end
        chk({nm, " drained"}, idle, 1);
    endtask

    int base;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset resp_id", resp_id, 0);
        chk("reset resp_out", resp_out, 0);
        chk("reset op_count", op_count, 0);
        chk("reset busy", busy, 0);
        #1 rst = 1'b0;

        push(0, 3, 5);
        wait_resp(0, 15, "single");
        drain("single");
        chk("single op_count", op_count, 1);

        push(0, 8'hFF, 8'h02);
        wait_resp(0, 8'hFE, "trunc");
        drain("trunc");
        chk("trunc op_count", op_count, 2);

        @(posedge clk);
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        base = glog.size();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 4; i++) push(i, 10 * k + i + 1, i + 7);
        drain("rr");
        chk("rr grant0", glog[base], 0);
        chk("rr grant1", glog[base + 1], 1);
        chk("rr grant2", glog[base + 2], 2);
        chk("rr grant3", glog[base + 3], 3);
        chk("rr grant4", glog[base + 4], 0);
        chk("rr op_count", op_count, 8);

        resp_ready = 1'b0;
        push(0, 2, 3);
        push(1, 4, 5);
        push(2, 6, 7);
        repeat (6) @(posedge clk);
        #3;
        chk("bp resp_valid", resp_valid, 1);
        chk("bp resp_id", resp_id, 0);
        chk("bp resp_out", resp_out, 6);
        chk("bp req_ready", req_ready, 0);
        resp_ready = 1'b1;
        wait_resp(0, 6, "bp r0");
        wait_resp(1, 20, "bp r1");
        wait_resp(2, 42, "bp r2");
        drain("bp");
        chk("bp op_count", op_count, 11);

        push(1, 1, 1);
        drain("skip pre");
        base = glog.size();
        push(1, 3, 3);
        push(3, 5, 5);
        drain("skip");
        chk("skip first", glog[base], 3);
        chk("skip second", glog[base + 1], 1);

        resp_ready = 1'b0;
        push(0, 7, 7);
        push(1, 9, 9);
        push(2, 1, 2);
        repeat (4) @(posedge clk);
        #3;
        chk("full busy", busy, 1);
        chk("full req_ready", req_ready, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        for (int i = 0; i < 4; i++) hd[i] = tl[i];
        #1;
        chk("mid rst resp_valid", resp_valid, 0);
        chk("mid rst busy", busy, 0);
        chk("mid rst op_count", op_count, 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        resp_ready = 1'b1;
        base = glog.size();
        push(1, 2, 2);
        push(0, 3, 3);
        drain("post rst");
        chk("post rst first", glog[base], 0);
        chk("post rst second", glog[base + 1], 1);
        chk("post rst op_count", op_count, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
